// File: rtl/emu_run_ctrl.sv
// emu_run_ctrl: run control for the emulation harness (target fire, scan clock enables, cycle/step counting, pause logic)
// Ports:
//   clk, resetn          host clock, synchronous active-low reset
//   trig_i, stall_i      DUT trigger levels, model stall
//   do_pause_i/resume_i  host pulse requests
//   scan_i               per-chain scan enables
//   *_write_i/*_wdata_i  host loads of mask, cycle counter, step counter, compare value/enable
//   pause_o, run_en_o    pause state, target fire / DUT clock enable
//   scan_clk_en_o        per-chain clock enables
//   count_o, step_o      cycle counter, remaining steps
//   trig_mask_o          current trigger mask
//   trig_hit_o, reason_o sticky trigger hits, sticky pause reason {host, cmp, step, trig}
//   pause_pulse_o        one-cycle pulse on pause rising edge
module emu_run_ctrl #(
    parameter int CNT_WIDTH    = 64,
    parameter int NUM_TRIG     = 4,
    parameter int NUM_SCAN     = 2,
    parameter bit START_PAUSED = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_TRIG-1:0]  trig_i,
    input  logic                 stall_i,
    input  logic                 do_pause_i,
    input  logic                 do_resume_i,
    input  logic [NUM_SCAN-1:0]  scan_i,
    input  logic                 mask_write_i,
    input  logic [NUM_TRIG-1:0]  mask_wdata_i,
    input  logic                 count_write_i,
    input  logic [CNT_WIDTH-1:0] count_wdata_i,
    input  logic                 step_write_i,
    input  logic [CNT_WIDTH-1:0] step_wdata_i,
    input  logic                 cmp_write_i,
    input  logic [CNT_WIDTH-1:0] cmp_wdata_i,
    input  logic                 cmp_en_wdata_i,
    output logic                 pause_o,
    output logic                 run_en_o,
    output logic [NUM_SCAN-1:0]  scan_clk_en_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic [CNT_WIDTH-1:0] step_o,
    output logic [NUM_TRIG-1:0]  trig_mask_o,
    output logic [NUM_TRIG-1:0]  trig_hit_o,
    output logic [3:0]           reason_o,
    output logic                 pause_pulse_o
);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    logic                 pause_q, pause_d, pulse_q, cmp_en_q;
    logic [CNT_WIDTH-1:0] count_q, count_d, step_q, step_d, cmp_q;
    logic [NUM_TRIG-1:0]  mask_q, hit_q, hit_d, trig_m;
    logic [3:0]           reason_q, reason_d;
    logic                 run_en, step_ev, cmp_ev, trig_ev, any_ev;
    always_comb begin
        run_en   = !pause_q && !stall_i;
        trig_m   = trig_i & mask_q;
        count_d  = count_write_i ? count_wdata_i : run_en ? count_q + ONE : count_q;
        step_d   = step_write_i ? step_wdata_i : (step_q == '0 || !run_en) ? step_q : step_q - ONE;
        // a host write of zero over a live countdown also counts as expiry
        step_ev  = step_q != '0 && step_d == '0;
        // fires on the cycle that brings count to cmp, so the target stops with count == cmp
        cmp_ev   = cmp_en_q && run_en && !count_write_i && (count_q + ONE) == cmp_q;
        trig_ev  = run_en && |trig_m;
        any_ev   = trig_ev || step_ev || cmp_ev || do_pause_i;
        pause_d  = any_ev || (!do_resume_i && pause_q);
        reason_d = any_ev ? reason_q | {do_pause_i, cmp_ev, step_ev, trig_ev} : do_resume_i ? 4'b0 : reason_q;
        hit_d    = any_ev ? hit_q | trig_m : do_resume_i ? '0 : hit_q;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pause_q  <= START_PAUSED;
            pulse_q  <= 1'b0;
            count_q  <= '0;
            step_q   <= '0;
            cmp_q    <= '0;
            cmp_en_q <= 1'b0;
            mask_q   <= '1;
            hit_q    <= '0;
            reason_q <= '0;
        end else begin
            pause_q  <= pause_d;
            pulse_q  <= pause_d && !pause_q;
            count_q  <= count_d;
            step_q   <= step_d;
            hit_q    <= hit_d;
            reason_q <= reason_d;
            if (cmp_write_i) begin
                cmp_q    <= cmp_wdata_i;
                cmp_en_q <= cmp_en_wdata_i;
            end
            if (mask_write_i) mask_q <= mask_wdata_i;
        end
    end
    assign pause_o       = pause_q;
    assign run_en_o      = run_en;
    assign scan_clk_en_o = {NUM_SCAN{run_en}} | scan_i;
    assign count_o       = count_q;
    assign step_o        = step_q;
    assign trig_mask_o   = mask_q;
    assign trig_hit_o    = hit_q;
    assign reason_o      = reason_q;
    assign pause_pulse_o = pulse_q;
endmodule

// File: tb/tb_emu_run_ctrl.sv
// tb_emu_run_ctrl: directed and randomized checks of emu_run_ctrl against a cycle-level reference model
module tb_emu_run_ctrl;
    logic        clk = 1'b0, resetn = 1'b0;
    logic [3:0]  trig = '0, mask_wdata = '0;
    logic        stall = 1'b0, do_pause = 1'b0, do_resume = 1'b0;
    logic [1:0]  scan = '0;
    logic        mask_write = 1'b0, count_write = 1'b0, step_write = 1'b0, cmp_write = 1'b0, cmp_en_wdata = 1'b0;
    logic [63:0] count_wdata = '0, step_wdata = '0, cmp_wdata = '0;
    logic        pause, run_en, pause_pulse;
    logic [1:0]  scan_clk_en;
    logic [63:0] count, step;
    logic [3:0]  trig_mask, trig_hit, reason;
    int n_vec = 0, n_bad = 0;
    bit              m_pause = 1'b0, m_pp = 1'b0, m_cmp_en = 1'b0;
    longint unsigned m_count = 0, m_step = 0, m_cmp = 0;
    bit [3:0]        m_mask = 4'hF, m_hit = 4'h0, m_reason = 4'h0;
    always #5 clk = ~clk;
    emu_run_ctrl dut (
        .clk(clk), .resetn(resetn), .trig_i(trig), .stall_i(stall),
        .do_pause_i(do_pause), .do_resume_i(do_resume), .scan_i(scan),
        .mask_write_i(mask_write), .mask_wdata_i(mask_wdata),
        .count_write_i(count_write), .count_wdata_i(count_wdata),
        .step_write_i(step_write), .step_wdata_i(step_wdata),
        .cmp_write_i(cmp_write), .cmp_wdata_i(cmp_wdata), .cmp_en_wdata_i(cmp_en_wdata),
        .pause_o(pause), .run_en_o(run_en), .scan_clk_en_o(scan_clk_en),
        .count_o(count), .step_o(step), .trig_mask_o(trig_mask),
        .trig_hit_o(trig_hit), .reason_o(reason), .pause_pulse_o(pause_pulse)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic model_step();
        bit run, s_ev, c_ev, t_ev, nxt;
        longint unsigned nstep;
        bit [3:0] tm;
        if (!resetn) begin
            m_pause = 1'b0; m_pp = 1'b0; m_count = 0; m_step = 0; m_cmp = 0; m_cmp_en = 1'b0;
            m_mask = 4'hF; m_hit = 4'h0; m_reason = 4'h0;
            return;
        end
        run = !m_pause && !stall;
        tm  = trig & m_mask;
        if (step_write) nstep = step_wdata;
        else if (m_step == 0) nstep = 0;
        else if (run) nstep = m_step - 1;
        else nstep = m_step;
        s_ev = m_step != 0 && nstep == 0;
        c_ev = m_cmp_en && run && !count_write && (m_count + 1 == m_cmp);
        t_ev = run && tm != 0;
        if (s_ev || c_ev || t_ev || do_pause) begin
            m_reason |= {do_pause, c_ev, s_ev, t_ev};
            m_hit |= tm;
            nxt = 1'b1;
        end else if (do_resume) begin
            m_reason = 4'h0; m_hit = 4'h0; nxt = 1'b0;
        end else nxt = m_pause;
        m_pp = nxt && !m_pause;
        m_pause = nxt;
        if (count_write) m_count = count_wdata;
        else if (run) m_count++;
        m_step = nstep;
        if (cmp_write) begin m_cmp = cmp_wdata; m_cmp_en = cmp_en_wdata; end
        if (mask_write) m_mask = mask_wdata;
    endtask
    task automatic tick();
        bit run;
        #1;
        run = !m_pause && !stall;
        chk("run_en", run_en, run);
        chk("scan_clk_en", scan_clk_en, {2{run}} | scan);
        model_step();
        @(posedge clk); #1;
        {do_pause, do_resume, mask_write, count_write, step_write, cmp_write} = '0;
        chk("pause", pause, m_pause);
        chk("pause_pulse", pause_pulse, m_pp);
        chk("count", count, m_count);
        chk("step", step, m_step);
        chk("trig_mask", trig_mask, m_mask);
        chk("trig_hit", trig_hit, m_hit);
        chk("reason", reason, m_reason);
    endtask
    initial begin
        int runs;
        logic [63:0] saved_count, saved_step;
        @(posedge clk); #1;
        tick();
        chk("rst_mask", trig_mask, 4'hF);
        chk("rst_pause", pause, 1'b0);
        resetn = 1'b1;
        // step countdown
        step_write = 1'b1; step_wdata = 5; count_write = 1'b1; count_wdata = 0;
        tick();
        runs = 0;
        for (int i = 0; i < 10; i++) begin
            if (run_en) runs++;
            tick();
        end
        chk("step_runs", runs, 5);
        chk("step_pause", pause, 1'b1);
        chk("step_reason", reason, 4'b0010);
        chk("step_zero", step, 0);
        chk("step_count", count, 5);
        // compare breakpoint
        do_resume = 1'b1; count_write = 1'b1; count_wdata = 0; cmp_write = 1'b1; cmp_wdata = 100; cmp_en_wdata = 1'b1;
        tick();
        for (int i = 0; i < 200 && !pause; i++) tick();
        chk("cmp_count", count, 100);
        chk("cmp_reason", reason, 4'b0100);
        chk("cmp_pulse", pause_pulse, 1'b1);
        tick();
        chk("cmp_pulse_w", pause_pulse, 1'b0);
        do_resume = 1'b1; count_write = 1'b1; count_wdata = 64'hFFFF_FFFF_FFFF_FFFE; cmp_write = 1'b1; cmp_wdata = 1; cmp_en_wdata = 1'b1;
        tick();
        for (int i = 0; i < 10 && !pause; i++) tick();
        chk("wrap_count", count, 1);
        chk("wrap_reason", reason, 4'b0100);
        // trigger mask
        do_resume = 1'b1; mask_write = 1'b1; mask_wdata = 4'b0101; count_write = 1'b1; count_wdata = 19; cmp_write = 1'b1; cmp_en_wdata = 1'b0;
        tick();
        trig = 4'b0010; tick(); trig = '0;
        chk("mask_nopause", pause, 1'b0);
        trig = 4'b0100; tick(); trig = '0;
        chk("trig_pause", pause, 1'b1);
        chk("trig_count", count, 21);
        chk("trig_hit_v", trig_hit, 4'b0100);
        chk("trig_reason", reason, 4'b0001);
        // stall and scan
        do_resume = 1'b1; stall = 1'b1; tick();
        saved_count = count;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_count", count, saved_count);
        chk("stall_run", run_en, 1'b0);
        stall = 1'b0; do_pause = 1'b1; tick();
        saved_count = count; saved_step = step;
        scan = 2'b10; #1;
        chk("scan_paused", scan_clk_en, 2'b10);
        tick(); tick();
        chk("scan_count", count, saved_count);
        chk("scan_step", step, saved_step);
        chk("scan_pause", pause, 1'b1);
        scan = '0;
        // simultaneous pause, resume and step expiry
        do_resume = 1'b1; tick();
        step_write = 1'b1; step_wdata = 1; tick();
        do_pause = 1'b1; do_resume = 1'b1; tick();
        chk("sim_pause", pause, 1'b1);
        chk("sim_reason", reason, 4'b1010);
        do_resume = 1'b1; tick();
        chk("res_pause", pause, 1'b0);
        chk("res_reason", reason, 4'b0000);
        chk("res_hit", trig_hit, 4'b0000);
        // reset mid-run
        step_write = 1'b1; step_wdata = 3; tick();
        tick();
        resetn = 1'b0; tick(); resetn = 1'b1;
        chk("mrst_pulse", pause_pulse, 1'b0);
        chk("mrst_step", step, 0);
        chk("mrst_count", count, 0);
        tick(); tick(); tick();
        chk("mrst_nopause", pause, 1'b0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            resetn       = $urandom_range(0, 199) != 0;
            trig         = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            stall        = $urandom_range(0, 3) == 0;
            do_pause     = $urandom_range(0, 29) == 0;
            do_resume    = $urandom_range(0, 5) == 0;
            scan         = 2'($urandom);
            mask_write   = $urandom_range(0, 49) == 0;
            mask_wdata   = 4'($urandom);
            count_write  = $urandom_range(0, 49) == 0;
            count_wdata  = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 50));
            step_write   = $urandom_range(0, 19) == 0;
            step_wdata   = 64'($urandom_range(0, 12));
            cmp_write    = $urandom_range(0, 19) == 0;
            cmp_wdata    = m_count + 64'($urandom_range(0, 8));
            cmp_en_wdata = $urandom_range(0, 2) != 0;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
